// File: rtl/wb_retire_if.sv
// Retire-bundle handshake between the commit logic and the writeback/retire stage.
interface wb_retire_if #(
    parameter int unsigned NPORT  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SIDE_W = 168
) ();
    logic                     flush;
    logic                     valid;
    logic                     ready;
    logic [NPORT-1:0]         lane_v;
    logic [NPORT*32-1:0]      pc;
    logic [NPORT-1:0]         we;
    logic [NPORT*5-1:0]       waddr;
    logic [NPORT*DATA_W-1:0]  wdata;
    logic [SIDE_W-1:0]        side;

    modport master (output flush, valid, lane_v, pc, we, waddr, wdata, side, input ready);
    modport slave  (input flush, valid, lane_v, pc, we, waddr, wdata, side, output ready);
endinterface

// File: rtl/wb_retire_stage.sv
// Writeback/retire stage: one-cycle register-file write pulse per accepted bundle,
// plus a trace FIFO that serializes retired lanes one per cycle for debug.
module wb_retire_stage #(
    parameter int unsigned NPORT       = 2,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SIDE_W      = 168,
    parameter int unsigned TRACE_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    wb_retire_if.slave              in_if,
    output logic [NPORT-1:0]        rf_we_o,
    output logic [NPORT*5-1:0]      rf_waddr_o,
    output logic [NPORT*DATA_W-1:0] rf_wdata_o,
    output logic                    side_valid_o,
    output logic [SIDE_W-1:0]       side_o,
    output logic [31:0]             debug_wb_pc_o,
    output logic [3:0]              debug_wb_rf_wen_o,
    output logic [4:0]              debug_wb_rf_wnum_o,
    output logic [DATA_W-1:0]       debug_wb_rf_wdata_o
);
    localparam int unsigned PTR_W      = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam int unsigned CNT_W      = $clog2(TRACE_DEPTH + 1);
    localparam int unsigned LANE_CNT_W = $clog2(NPORT + 1);

    typedef struct packed {
        logic [31:0]       pc;
        logic              we;
        logic [4:0]        waddr;
        logic [DATA_W-1:0] wdata;
    } trace_t;

    trace_t                  mem_q [TRACE_DEPTH];
    logic [PTR_W-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ready_q, ready_d;
    logic                    accept_c, pop_c;
    logic [LANE_CNT_W-1:0]   push_n_c;
    logic [NPORT-1:0]        we_eff_c;
    logic [PTR_W-1:0]        slot_c [NPORT];

    logic [NPORT-1:0]        rf_we_q;
    logic [NPORT*5-1:0]      rf_waddr_q;
    logic [NPORT*DATA_W-1:0] rf_wdata_q;
    logic                    side_valid_q;
    logic [SIDE_W-1:0]       side_q;
    trace_t                  dbg_q;

    assign accept_c = in_if.valid & ready_q & ~in_if.flush;
    assign pop_c    = (cnt_q != '0);

    // Youngest-writer suppression and compacted FIFO slot per valid lane.
    always_comb begin
        push_n_c = '0;
        we_eff_c = '0;
        for (int i = 0; i < NPORT; i++) begin
            slot_c[i] = PTR_W'((int'(wptr_q) + int'(push_n_c)) % int'(TRACE_DEPTH));
            if (in_if.lane_v[i]) push_n_c = push_n_c + LANE_CNT_W'(1);
            we_eff_c[i] = in_if.lane_v[i] & in_if.we[i];
            for (int j = i + 1; j < NPORT; j++) begin
                if (in_if.lane_v[j] && in_if.we[j] &&
                    (in_if.waddr[j*5 +: 5] == in_if.waddr[i*5 +: 5]))
                    we_eff_c[i] = 1'b0;
            end
        end
    end

    always_comb begin
        int cnt_nxt;
        cnt_nxt = int'(cnt_q) + (accept_c ? int'(push_n_c) : 0) - (pop_c ? 1 : 0);
        cnt_d   = CNT_W'(cnt_nxt);
        ready_d = (int'(TRACE_DEPTH) - cnt_nxt) >= int'(NPORT);
        wptr_d  = accept_c ? PTR_W'((int'(wptr_q) + int'(push_n_c)) % int'(TRACE_DEPTH)) : wptr_q;
        rptr_d  = pop_c ? PTR_W'((int'(rptr_q) + 1) % int'(TRACE_DEPTH)) : rptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Stage register: anything other than an accept loads a bubble.
    always_ff @(posedge clk) begin
        if (rst || !accept_c) begin
            rf_we_q      <= '0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            side_valid_q <= 1'b0;
            side_q       <= '0;
        end else begin
            rf_we_q      <= we_eff_c;
            rf_waddr_q   <= in_if.waddr;
            rf_wdata_q   <= in_if.wdata;
            side_valid_q <= |in_if.lane_v;
            side_q       <= in_if.side;
        end
    end

    always_ff @(posedge clk) begin
        if (accept_c) begin
            for (int i = 0; i < NPORT; i++) begin
                if (in_if.lane_v[i])
                    mem_q[slot_c[i]] <= '{pc: in_if.pc[i*32 +: 32], we: in_if.we[i],
                                         waddr: in_if.waddr[i*5 +: 5],
                                         wdata: in_if.wdata[i*DATA_W +: DATA_W]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !pop_c) dbg_q <= '0;
        else               dbg_q <= mem_q[rptr_q];
    end

    assign in_if.ready         = ready_q;
    assign rf_we_o             = rf_we_q;
    assign rf_waddr_o          = rf_waddr_q;
    assign rf_wdata_o          = rf_wdata_q;
    assign side_valid_o        = side_valid_q;
    assign side_o              = side_q;
    assign debug_wb_pc_o       = dbg_q.pc;
    assign debug_wb_rf_wen_o   = {4{dbg_q.we}};
    assign debug_wb_rf_wnum_o  = dbg_q.waddr;
    assign debug_wb_rf_wdata_o = dbg_q.wdata;
endmodule

// File: tb/tb_wb_retire_stage.sv
// Self-checking bench for wb_retire_stage: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_wb_retire_stage;
    localparam int unsigned NP = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 168;
    localparam int unsigned TD = 8;

    typedef struct {
        logic [31:0]   pc;
        logic          we;
        logic [4:0]    waddr;
        logic [DW-1:0] wdata;
    } entry_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_retire_if #(.NPORT(NP), .DATA_W(DW), .SIDE_W(SW)) bus ();

    logic [NP-1:0]    rf_we;
    logic [NP*5-1:0]  rf_waddr;
    logic [NP*DW-1:0] rf_wdata;
    logic             side_valid;
    logic [SW-1:0]    side;
    logic [31:0]      dbg_pc;
    logic [3:0]       dbg_wen;
    logic [4:0]       dbg_wnum;
    logic [DW-1:0]    dbg_wdata;

    wb_retire_stage #(.NPORT(NP), .DATA_W(DW), .SIDE_W(SW), .TRACE_DEPTH(TD)) dut (
        .clk(clk), .rst(rst), .in_if(bus),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .side_valid_o(side_valid), .side_o(side),
        .debug_wb_pc_o(dbg_pc), .debug_wb_rf_wen_o(dbg_wen),
        .debug_wb_rf_wnum_o(dbg_wnum), .debug_wb_rf_wdata_o(dbg_wdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    entry_t           fifo_m [$];
    logic             exp_ready;
    logic [NP-1:0]    exp_rf_we;
    logic [NP*5-1:0]  exp_waddr;
    logic [NP*DW-1:0] exp_wdata;
    logic             exp_sv;
    logic [SW-1:0]    exp_side;
    entry_t           exp_dbg;
    logic [31:0]      pc_ctr;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: last writer per register in a bundle wins; FIFO is a plain queue.
    task automatic model_update();
        bit acc;
        int last [32];
        if (rst) begin
            fifo_m.delete();
            exp_ready = 1'b0; exp_rf_we = '0; exp_waddr = '0; exp_wdata = '0;
            exp_sv = 1'b0; exp_side = '0; exp_dbg = '{default: '0};
            return;
        end
        acc = bus.valid && exp_ready && !bus.flush;
        exp_rf_we = '0; exp_waddr = '0; exp_wdata = '0; exp_sv = 1'b0; exp_side = '0;
        if (acc) begin
            foreach (last[a]) last[a] = -1;
            for (int i = 0; i < NP; i++)
                if (bus.lane_v[i] && bus.we[i]) last[bus.waddr[i*5 +: 5]] = i;
            for (int i = 0; i < NP; i++)
                exp_rf_we[i] = bus.lane_v[i] && bus.we[i] && (last[bus.waddr[i*5 +: 5]] == i);
            exp_waddr = bus.waddr;
            exp_wdata = bus.wdata;
            exp_sv    = |bus.lane_v;
            exp_side  = bus.side;
        end
        if (fifo_m.size() > 0) exp_dbg = fifo_m.pop_front();
        else                   exp_dbg = '{default: '0};
        if (acc)
            for (int i = 0; i < NP; i++)
                if (bus.lane_v[i])
                    fifo_m.push_back('{pc: bus.pc[i*32 +: 32], we: bus.we[i],
                                       waddr: bus.waddr[i*5 +: 5], wdata: bus.wdata[i*DW +: DW]});
        exp_ready = (int'(TD) - fifo_m.size()) >= int'(NP);
    endtask

    task automatic check_all();
        chk("in_ready",   bus.ready,  exp_ready);
        chk("rf_we",      rf_we,      exp_rf_we);
        chk("rf_waddr",   rf_waddr,   exp_waddr);
        chk("rf_wdata",   rf_wdata,   exp_wdata);
        chk("side_valid", side_valid, exp_sv);
        chk("side",       side,       exp_side);
        chk("dbg_pc",     dbg_pc,     exp_dbg.pc);
        chk("dbg_wen",    dbg_wen,    {4{exp_dbg.we}});
        chk("dbg_wnum",   dbg_wnum,   exp_dbg.waddr);
        chk("dbg_wdata",  dbg_wdata,  exp_dbg.wdata);
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        bus.valid = 1'b0; bus.flush = 1'b0; bus.lane_v = '0; bus.we = '0;
        bus.pc = '0; bus.waddr = '0; bus.wdata = '0; bus.side = '0;
    endtask

    task automatic set_lane(input int i, input logic v, input logic [31:0] pc,
                            input logic we, input logic [4:0] wa, input logic [DW-1:0] wd);
        bus.lane_v[i] = v;
        bus.pc[i*32 +: 32] = pc;
        bus.we[i] = we;
        bus.waddr[i*5 +: 5] = wa;
        bus.wdata[i*DW +: DW] = wd;
    endtask

    task automatic two_lane_bundle(input logic [4:0] wa0, input logic [4:0] wa1);
        bus.valid = 1'b1;
        set_lane(0, 1'b1, pc_ctr,      1'b1, wa0, DW'($urandom()));
        set_lane(1, 1'b1, pc_ctr + 4,  1'b1, wa1, DW'($urandom()));
        bus.side = SW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        pc_ctr = pc_ctr + 8;
    endtask

    initial begin
        bit saw_drop;
        pc_ctr = 32'hBFC0_1000;
        rst = 1'b1;
        idle();
        @(negedge clk);
        step(); step();                          // held in reset
        rst = 1'b0;
        step();                                  // first cycle out of reset

        // Two independent writers, then drain the trace.
        bus.valid = 1'b1;
        set_lane(0, 1'b1, 32'hBFC0_0000, 1'b1, 5'd3, 32'h11);
        set_lane(1, 1'b1, 32'hBFC0_0004, 1'b1, 5'd4, 32'h22);
        step();
        idle();
        repeat (3) step();

        // Same destination: younger lane wins the write port, trace keeps both.
        bus.valid = 1'b1;
        set_lane(0, 1'b1, 32'hBFC0_0008, 1'b1, 5'd5, 32'hA);
        set_lane(1, 1'b1, 32'hBFC0_000C, 1'b1, 5'd5, 32'hB);
        step();
        idle();
        repeat (3) step();

        // Back-to-back bundles until backpressure appears.
        saw_drop = 1'b0;
        for (int c = 0; c < 10; c++) begin
            two_lane_bundle(5'(c), 5'(c + 10));
            step();
            if (bus.ready == 1'b0) saw_drop = 1'b1;
        end
        chk("ready_dropped", saw_drop, 1'b1);
        idle();
        repeat (12) step();

        // Flush discards the incoming bundle but not queued trace entries.
        two_lane_bundle(5'd1, 5'd2);
        step();
        two_lane_bundle(5'd6, 5'd7);
        bus.flush = 1'b1;
        step();
        idle();
        repeat (4) step();

        // Reset with five entries queued.
        for (int c = 0; c < 4; c++) begin
            two_lane_bundle(5'(c + 1), 5'(c + 20));
            step();
        end
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        repeat (2) step();

        // Random traffic with narrow register range to provoke collisions.
        for (int c = 0; c < 600; c++) begin
            idle();
            rst = ($urandom_range(0, 99) == 0);
            bus.valid = ($urandom_range(0, 9) < 8);
            bus.flush = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < NP; i++) begin
                set_lane(i, 1'($urandom_range(0, 3) != 0), pc_ctr, 1'($urandom()),
                         5'($urandom_range(0, 3)), DW'($urandom()));
                pc_ctr = pc_ctr + 4;
            end
            bus.side = SW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
            step();
        end
        rst = 1'b0;
        idle();
        repeat (12) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/wb_retire_stage.md
WB_RETIRE_STAGE -- requirements
Module: wb_retire_stage

Interface
REQ-001 Parameter NPORT, default 2, number of retire lanes (1..4); lane 0 is oldest in program order.
REQ-002 Parameter DATA_W, default 32, register write-data width.
REQ-003 Parameter SIDE_W, default 168, width of the side payload (cp0/hilo/exception bundle), passed through unchanged.
REQ-004 Parameter TRACE_DEPTH, default 8, debug trace FIFO depth in entries; power of two; TRACE_DEPTH >= NPORT.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 flush  in  1  discard the bundle being captured this cycle.
REQ-008 in_valid  in  1  upstream bundle valid.
REQ-009 in_ready  out  1  stage can accept a bundle this cycle.
REQ-010 in_lane_v  in  NPORT  per-lane instruction valid.
REQ-011 in_pc  in  NPORT*32  per-lane PC.
REQ-012 in_we  in  NPORT  per-lane register write enable.
REQ-013 in_waddr  in  NPORT*5  per-lane destination register.
REQ-014 in_wdata  in  NPORT*DATA_W  per-lane write data.
REQ-015 in_side  in  SIDE_W  side payload.
REQ-016 rf_we / rf_waddr / rf_wdata  out  NPORT / NPORT*5 / NPORT*DATA_W  registered register-file write ports.
REQ-017 side_valid / side_o  out  1 / SIDE_W  registered side payload and its qualifier.
REQ-018 debug_wb_pc / debug_wb_rf_wen / debug_wb_rf_wnum / debug_wb_rf_wdata  out  32 / 4 / 5 / DATA_W  serialized one-lane-per-cycle trace.

Function
REQ-019 Accept occurs when in_valid=1 and in_ready=1 and flush=0; on accept the stage register SHALL capture all lane and side fields, visible on outputs the next cycle.
REQ-020 On any cycle without accept (including flush=1), the stage register SHALL load a bubble: rf_we=0, side_valid=0, data fields 0.
REQ-021 Register writes SHALL be single-cycle pulses: a captured bundle drives outputs for exactly one cycle.
REQ-022 rf_we[i] SHALL equal in_lane_v[i] & in_we[i], except when a younger lane j>i in the same bundle also writes the same nonzero-or-zero waddr, in which case rf_we[i]=0 (youngest writer wins).
REQ-023 side_valid SHALL be 1 for a captured bundle with any in_lane_v bit set.
REQ-024 Trace FIFO: on accept, one entry {pc, we, waddr, wdata} SHALL be pushed per valid lane, in ascending lane order; invalid lanes push nothing; suppressed writers (REQ-022) push with we as given by in_we.
REQ-025 One entry SHALL be popped per cycle when FIFO non-empty; popped entry drives debug outputs that cycle, debug_wb_rf_wen={4{we}}.
REQ-026 FIFO empty: debug_wb_rf_wen=0, debug_wb_pc=0, wnum=0, wdata=0.
REQ-027 in_ready SHALL be registered: 1 iff free entries after this cycle's push/pop >= NPORT; never combinationally dependent on in_valid.
REQ-028 Occupancy counter SHALL handle simultaneous push of k entries and pop of 1 as count+k-1; read/write pointers wrap modulo TRACE_DEPTH.
REQ-029 FIFO SHALL never overflow; accept while free < NPORT is impossible by REQ-027.
REQ-030 flush SHALL NOT drop entries already in the trace FIFO.

Reset
REQ-031 While rst=1: all outputs 0, in_ready=0, FIFO pointers and count 0.
REQ-032 First cycle after rst deasserts: in_ready=1, FIFO empty, stage register bubble.
REQ-033 rst mid-operation SHALL discard stage register and all FIFO entries in the same edge.

Verification
REQ-034 Single bundle, NPORT=2, lanes {pc 0xBFC00000 we r3=0x11},{pc 0xBFC00004 we r4=0x22} -> next cycle rf_we=2'b11, then trace shows r3/0x11 then r4/0x22 on consecutive cycles.
REQ-035 Both lanes write r5 (0xA, 0xB) -> rf_we=2'b10, rf_wdata lane1=0xB; trace still shows both entries in order.
REQ-036 Back-to-back bundles every cycle, NPORT=2, TRACE_DEPTH=8 -> in_ready drops to 0 when free<2, no entry lost, trace PCs strictly in program order.
REQ-037 flush=1 with in_valid=1 -> next cycle rf_we=0, side_valid=0, nothing pushed; earlier FIFO entries still drain.
REQ-038 rst asserted with 5 entries queued -> next cycle debug_wb_rf_wen=0, count=0; after deassert in_ready=1.
